// File: rtl/fetch_seq_ctrl_if.sv
// fetch_seq_ctrl_if
//   Groups the decode-side inputs and the fetch-side outputs of the fetch
//   sequencing controller into one bundle. clk and rst_n are not included.
//
//   slave  modport : used by fetch_seq_ctrl (receives decoder info, drives
//                    pc/ispb/stall/link outputs)
//   master modport : used by the decoder / environment (drives decoder info,
//                    observes the controller outputs)
//
//   Signals:
//     run_en        1  advance enable; 0 freezes the controller
//     ib_in         1  branch taken flag for the instruction in decode
//     bl_in         1  branch-with-link flag
//     bv_in        32  sign-extended byte offset of the branch
//     ld_in         1  instruction in decode is an executed load
//     ld_rd_in      4  destination register of that load
//     nxt_rn_in     4  Rn field of the instruction being fetched
//     pc_out       32  fetch address
//     ispb_out      1  squash the instruction in decode
//     stall_out     1  hold IF/ID and the fetch PC
//     link_we_out   1  single-cycle r14 write strobe
//     link_val_out 32  return address for r14
interface fetch_seq_ctrl_if;
  logic        run_en;
  logic        ib_in;
  logic        bl_in;
  logic [31:0] bv_in;
  logic        ld_in;
  logic [3:0]  ld_rd_in;
  logic [3:0]  nxt_rn_in;
  logic [31:0] pc_out;
  logic        ispb_out;
  logic        stall_out;
  logic        link_we_out;
  logic [31:0] link_val_out;

  modport slave (
    input  run_en, ib_in, bl_in, bv_in, ld_in, ld_rd_in, nxt_rn_in,
    output pc_out, ispb_out, stall_out, link_we_out, link_val_out
  );

  modport master (
    output run_en, ib_in, bl_in, bv_in, ld_in, ld_rd_in, nxt_rn_in,
    input  pc_out, ispb_out, stall_out, link_we_out, link_val_out
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl
//   Sequencing controller for the fetch/decode front end of the 32-bit core.
//   Owns the fetch PC, redirects fetch on decoded branches (with an r14 link
//   write for BL), squashes the instruction in decode after a redirect, and
//   optionally inserts a one-cycle bubble on a load-use hazard.
//
//   Optional feature macro: LOAD_USE_STALL_EN
//     defined   : load-use hazard detection and the STALL state are present
//     undefined : ld_in / ld_rd_in / nxt_rn_in are ignored, stall_out is 0
//
//   Parameters:
//     RESET_PC      fetch address loaded on reset
//     FLUSH_CYCLES  cycles ispb is held after a taken branch (1..3)
//
//   Ports:
//     clk    core clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    fetch_seq_ctrl_if.slave (decoder inputs, fetch outputs)
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input logic           clk,
  input logic           rst_n,
  fetch_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

  state_t      state;
  logic [1:0]  flush_cnt;
  logic [31:0] pc;
  logic [31:0] dec_pc;
  logic        ispb;
  logic        stall;
  logic        link_we;
  logic [31:0] link_val;
  logic        hazard;

  // A load in decode whose destination feeds the Rn of the instruction
  // being fetched needs one bubble before that instruction can decode.
`ifdef LOAD_USE_STALL_EN
  assign hazard = bus.ld_in && (bus.nxt_rn_in == bus.ld_rd_in);
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{bus.ld_in, bus.ld_rd_in, bus.nxt_rn_in};
  assign hazard = 1'b0;
`endif

  // Sequencing FSM. ispb and stall are registered alongside the state so
  // they always reflect the state being entered. While frozen every
  // register holds except the link strobe, which drops so a pulse never
  // stretches across a freeze.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 2'd0;
      pc        <= RESET_PC;
      dec_pc    <= RESET_PC;
      ispb      <= 1'b0;
      stall     <= 1'b0;
      link_we   <= 1'b0;
      link_val  <= 32'h0000_0000;
    end else if (!bus.run_en) begin
      link_we <= 1'b0;
    end else begin
      link_we <= 1'b0;
      unique case (state)
        RUN: begin
          if (bus.ib_in) begin
            // Branch wins over a hazard: the next instruction is squashed.
            pc        <= dec_pc + 32'd8 + bus.bv_in;
            dec_pc    <= pc;
            state     <= FLUSH;
            flush_cnt <= FLUSH_INIT;
            ispb      <= 1'b1;
            stall     <= 1'b0;
            if (bus.bl_in) begin
              link_we  <= 1'b1;
              link_val <= dec_pc + 32'd4;
            end
          end else if (hazard) begin
            pc     <= pc + 32'd4;
            dec_pc <= pc;
            state  <= STALL;
            ispb   <= 1'b1;
            stall  <= 1'b1;
          end else begin
            pc     <= pc + 32'd4;
            dec_pc <= pc;
          end
        end
        FLUSH: begin
          pc     <= pc + 32'd4;
          dec_pc <= pc;
          if (flush_cnt <= 2'd1) begin
            state     <= RUN;
            flush_cnt <= 2'd0;
            ispb      <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 2'd1;
          end
        end
        STALL: begin
          // PC and dec_pc hold; the dependent instruction stays in IF/ID.
          state <= RUN;
          ispb  <= 1'b0;
          stall <= 1'b0;
        end
        default: begin
          state     <= RUN;
          flush_cnt <= 2'd0;
          ispb      <= 1'b0;
          stall     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_out       = pc;
  assign bus.ispb_out     = ispb;
`ifdef LOAD_USE_STALL_EN
  assign bus.stall_out    = stall;
`else
  assign bus.stall_out    = 1'b0;
  logic unused_stall;
  assign unused_stall = stall;
`endif
  assign bus.link_we_out  = link_we;
  assign bus.link_val_out = link_val;

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Sequencing controller for the fetch/decode front end of the 32-bit core.
- Owns the fetch PC and generates the decoder squash input (ispb).
- Redirects fetch on decoded branches and produces the r14 link write for BL.
- Inserts a one-cycle bubble on a load-use hazard between the decoded load and the next fetched instruction.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- FLUSH_CYCLES, 1, number of cycles ispb is held after a taken branch; legal range 1..3.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- run_en, input, 1, 1 = advance; 0 = freeze all state (reset still applies).
- ib_in, input, 1, decoder branch-taken flag for the instruction in decode.
- bl_in, input, 1, decoder branch-link flag.
- bv_in, input, 32, decoder sign-extended byte offset (imm24<<2).
- ld_in, input, 1, instruction in decode is an executed load (decoder reg_we with the load/store class and L=1).
- ld_rd_in, input, 4, destination register of that load.
- nxt_rn_in, input, 4, Rn field [19:16] of the instruction currently being fetched.
- pc_out, output, 32, fetch address.
- ispb_out, output, 1, squash the instruction in decode; drives decoder ispb.
- stall_out, output, 1, hold the IF/ID register and the fetch PC this cycle.
- link_we_out, output, 1, one-cycle write strobe for r14.
- link_val_out, output, 32, return address for r14.

Behaviour:
- Internal dec_pc register holds the address of the instruction presented to the decoder.
- Reset (rst_n=0 at a clock edge):
  - pc_out=RESET_PC, dec_pc=RESET_PC, state=RUN, flush counter=0.
  - ispb_out=0, stall_out=0, link_we_out=0, link_val_out=0.
- Freeze: run_en=0 holds every register. link_we_out is forced 0 while frozen. No event is captured while frozen.
- States: RUN, FLUSH, STALL. ispb_out and stall_out are Moore outputs:
  - RUN: ispb_out=0, stall_out=0.
  - FLUSH: ispb_out=1, stall_out=0.
  - STALL: ispb_out=1, stall_out=1.
- RUN, with run_en=1:
  - Taken branch (ib_in=1):
    - pc_out <= dec_pc + 8 + bv_in, modulo 2^32 (wrap, no overflow flag).
    - dec_pc <= pc_out.
    - Go to FLUSH with counter=FLUSH_CYCLES.
    - If bl_in=1: link_we_out <= 1 and link_val_out <= dec_pc + 4, both valid the next cycle.
  - Load-use hazard (ld_in=1 and nxt_rn_in==ld_rd_in, no branch):
    - pc_out <= pc_out + 4, dec_pc <= pc_out.
    - Go to STALL.
  - Otherwise: pc_out <= pc_out + 4, dec_pc <= pc_out.
  - Priority: branch over hazard. The instruction after the branch is flushed anyway.
- FLUSH:
  - pc_out <= pc_out + 4, dec_pc <= pc_out.
  - Counter decrements each cycle; return to RUN when it reaches 1.
  - ib_in, ld_in and hazard detection are ignored (decode is squashed).
- STALL (exactly one cycle):
  - pc_out and dec_pc hold.
  - Dependent instruction stays in IF/ID; decode sees a bubble.
  - Always return to RUN. No hazard or branch is evaluated (decode is squashed).
- link_we_out is a single-cycle pulse. link_val_out holds its last value until the next BL.
- pc_out[1:0] is always 2'b00 given aligned RESET_PC and bv_in.
- Reset mid-FLUSH or mid-STALL returns to RUN at RESET_PC with no link pulse.

Optional Feature:
- Macro: LOAD_USE_STALL_EN.
- Defined: hazard detection and the STALL state as described.
- Undefined:
  - ld_in, ld_rd_in and nxt_rn_in are ignored.
  - STALL is unreachable; stall_out is constant 0.
  - Software must schedule around load-use.

Test Plan:
- Reset then 4 cycles run_en=1, no events -> pc_out 0,4,8,12,16; ispb_out=0 throughout.
- Branch at dec_pc=0x10 with bv_in=0x20, bl_in=0 -> next cycle pc_out=0x38, ispb_out=1 for 1 cycle (FLUSH_CYCLES=1), then pc_out=0x3C, 0x40 with ispb_out=0.
- BL at dec_pc=0x100 with bv_in=0xFFFF_FFF8 -> pc_out=0x100; link_we_out pulses 1 cycle with link_val_out=0x104; wrap case dec_pc=0xFFFF_FFF0, bv_in=0x10 -> pc_out=0x0000_0008.
- ld_in=1, ld_rd_in=3, nxt_rn_in=3 with pc_out=0x20 -> next cycle stall_out=1, ispb_out=1, pc_out holds 0x24 for 1 cycle, then increments to 0x28; with nxt_rn_in=4 -> no stall. With LOAD_USE_STALL_EN undefined -> stall_out never asserts.
- ib_in=1 and hazard in the same cycle -> branch taken, FLUSH entered, no STALL cycle; ib_in=1 during FLUSH -> ignored.
- FLUSH_CYCLES=3, branch then rst_n=0 in 2nd flush cycle -> pc_out=RESET_PC, ispb_out=0, no link pulse; run_en=0 for 3 cycles mid-run -> pc_out constant.
